// File: rtl/sum_res_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sum_res_ctrl_pkg
// Shared definitions for the adder/subtractor sequencing controller and its
// seven-segment scan sub-block: FSM state encoding, special digit codes that
// the downstream BCD-to-7-segment decoder must map, digit count, and a small
// helper for the tens-digit blanking rule.
// ---------------------------------------------------------------------------
package sum_res_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_CONV = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [3:0] DIG_BLANK  = 4'hF;
   localparam logic [3:0] DIG_MINUS  = 4'hA;
   localparam int         NUM_DIGITS = 4;

   // Leading-zero suppression for the tens position.
   function automatic logic [3:0] tens_digit(input logic [1:0] tens);
      return (tens == 2'd0) ? DIG_BLANK : {2'b00, tens};
   endfunction

endpackage

// File: rtl/sum_res_ctrl_disp_scan.sv
// ---------------------------------------------------------------------------
// disp_scan
// Free-running multiplexer for a 4-digit display. Each digit stays selected
// for REFRESH_DIV clock cycles; anode enables and the BCD code of the selected
// digit are registered together so they always change on the same edge.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   d0..d3          : digit codes (d0 = rightmost, selected first)
//   an  [3:0]       : anode enables, active-low, one-hot-low
//   bcd [3:0]       : code of the currently selected digit
// ---------------------------------------------------------------------------
module disp_scan
   import sum_res_ctrl_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   output logic [3:0] an,
   output logic [3:0] bcd
);

   localparam int             CW      = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    an_q, an_d;
   logic [3:0]    bcd_q, bcd_d;
   logic [3:0]    dig [NUM_DIGITS];

   assign dig[0] = d0;
   assign dig[1] = d1;
   assign dig[2] = d2;
   assign dig[3] = d3;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end
   end

   // Outputs are loaded from the next index so anode and code move together
   // on the wrap edge and each slot lasts exactly REFRESH_DIV cycles.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
         assign an_d[gi] = (idx_d != 2'(gi));
      end
   endgenerate

   assign bcd_d = dig[idx_d];

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= 2'd0;
         an_q  <= 4'b1110;
         bcd_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         an_q  <= an_d;
         bcd_q <= bcd_d;
      end
   end

   assign an  = an_q;
   assign bcd = bcd_q;

endmodule

// File: rtl/sum_res_ctrl.sv
// ---------------------------------------------------------------------------
// sum_res_ctrl
// Sequencer for an external shared 4-bit adder/subtractor and a 4-digit
// seven-segment display. A rising edge on start latches the operands, one
// cycle lets the datapath settle, the signed result is captured and split
// into sign + tens + ones by repeated subtraction of 10, and the display
// registers are loaded in one step while done pulses.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, A, B, Sel    : request edge, unsigned operands, 0=add 1=sub
//   alu_a/alu_b/alu_sel : latched operands to the shared datapath
//   alu_s, alu_co       : datapath sum and carry (sub: co=1 means A>=B)
//   busy, done          : operation in flight, one-cycle completion pulse
//   bcd, an             : multiplexed digit code, active-low anode enables
// ---------------------------------------------------------------------------
module sum_res_ctrl
   import sum_res_ctrl_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Sel,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic       alu_sel,
   input  logic [3:0] alu_s,
   input  logic       alu_co,
   output logic       busy,
   output logic       done,
   output logic [3:0] bcd,
   output logic [3:0] an
);

   state_t     state_q, state_d;
   logic       start_prev_q, start_prev_d;
   logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic       alu_sel_q, alu_sel_d;
   logic [4:0] mag_q, mag_d;
   logic [1:0] tens_q, tens_d;
   logic       neg_q, neg_d;
   logic       busy_q, busy_d, done_q, done_d;
   logic [3:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;

   always_comb begin
      state_d      = state_q;
      start_prev_d = start;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_sel_d    = alu_sel_q;
      mag_d        = mag_q;
      tens_d       = tens_q;
      neg_d        = neg_q;
      d0_d         = d0_q;
      d1_d         = d1_q;
      d2_d         = d2_q;
      d3_d         = d3_q;

      case (state_q)
         ST_IDLE: begin
            // Only a fresh edge seen in IDLE is accepted; edges while busy
            // are dropped rather than queued.
            if (start && !start_prev_q) begin
               alu_a_d   = A;
               alu_b_d   = B;
               alu_sel_d = Sel;
               state_d   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!alu_sel_q) begin
               mag_d = {alu_co, alu_s};
               neg_d = 1'b0;
            end else if (alu_co) begin
               mag_d = {1'b0, alu_s};
               neg_d = 1'b0;
            end else begin
               // Borrow: the datapath holds A-B mod 16, so negate it back.
               mag_d = {1'b0, 4'(~alu_s + 4'd1)};
               neg_d = 1'b1;
            end
            tens_d  = 2'd0;
            state_d = ST_CONV;
         end
         ST_CONV: begin
            if (mag_q >= 5'd10) begin
               mag_d  = mag_q - 5'd10;
               tens_d = tens_q + 2'd1;
            end else begin
               d0_d    = mag_q[3:0];
               d1_d    = tens_digit(tens_q);
               d2_d    = DIG_BLANK;
               d3_d    = (neg_q && (mag_q != 5'd0 || tens_q != 2'd0)) ? DIG_MINUS : DIG_BLANK;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         start_prev_q <= 1'b0;
         alu_a_q      <= 4'd0;
         alu_b_q      <= 4'd0;
         alu_sel_q    <= 1'b0;
         mag_q        <= 5'd0;
         tens_q       <= 2'd0;
         neg_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         d0_q         <= 4'd0;
         d1_q         <= DIG_BLANK;
         d2_q         <= DIG_BLANK;
         d3_q         <= DIG_BLANK;
      end else begin
         state_q      <= state_d;
         start_prev_q <= start_prev_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_sel_q    <= alu_sel_d;
         mag_q        <= mag_d;
         tens_q       <= tens_d;
         neg_q        <= neg_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         d0_q         <= d0_d;
         d1_q         <= d1_d;
         d2_q         <= d2_d;
         d3_q         <= d3_d;
      end
   end

   assign alu_a   = alu_a_q;
   assign alu_b   = alu_b_q;
   assign alu_sel = alu_sel_q;
   assign busy    = busy_q;
   assign done    = done_q;

   disp_scan #(
      .REFRESH_DIV (REFRESH_DIV)
   ) u_scan (
      .clk (clk),
      .rst (rst),
      .d0  (d0_q),
      .d1  (d1_q),
      .d2  (d2_q),
      .d3  (d3_q),
      .an  (an),
      .bcd (bcd)
   );

endmodule

// File: tb/tb_sum_res_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sum_res_ctrl
// Directed bench with a behavioural stand-in for the shared adder/subtractor.
// Stimulus pushes hand-computed expectations (done cycle and display digits)
// into a queue; a monitor pops one per done pulse and reads the digits back
// from the scanned bcd/an outputs over the following frame.
// ---------------------------------------------------------------------------
module tb_sum_res_ctrl;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [3:0] A = 4'd0, B = 4'd0;
   logic       Sel = 1'b0;
   logic [3:0] alu_a, alu_b;
   logic       alu_sel;
   logic [3:0] alu_s;
   logic       alu_co;
   logic       busy, done;
   logic [3:0] bcd, an;

   sum_res_ctrl #(.REFRESH_DIV(DIV)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .A       (A),
      .B       (B),
      .Sel     (Sel),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_sel (alu_sel),
      .alu_s   (alu_s),
      .alu_co  (alu_co),
      .busy    (busy),
      .done    (done),
      .bcd     (bcd),
      .an      (an)
   );

   // Shared datapath model: add gives a 5-bit sum, sub gives A-B mod 16 with
   // carry meaning "no borrow".
   always_comb begin
      if (alu_sel) begin
         alu_s  = alu_a - alu_b;
         alu_co = (alu_a >= alu_b);
      end else begin
         {alu_co, alu_s} = {1'b0, alu_a} + {1'b0, alu_b};
      end
   end

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_done = 0;
   always @(negedge clk) if (done === 1'b1) n_done <= n_done + 1;

   typedef struct {
      int         done_cyc;
      logic [3:0] d0, d1, d3;
   } exp_t;

   typedef struct {
      logic [3:0] a, b;
      logic       s;
      logic [3:0] d0, d1, d3;
      int         k;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp_v, exp_v, cyc);
      end
   endtask

   // Monitor: one expectation per done pulse, digits read back from the scan.
   int   seen [4];
   exp_t cur;
   bit   an_ok;
   initial begin
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               cur = sb.pop_front();
               chk("done_cycle", cyc, cur.done_cyc);
               for (int i = 0; i < 4; i++) seen[i] = -1;
               an_ok = 1'b1;
               repeat (4 * DIV) begin
                  @(negedge clk);
                  if (an == 4'b1110)      seen[0] = int'(bcd);
                  else if (an == 4'b1101) seen[1] = int'(bcd);
                  else if (an == 4'b1011) seen[2] = int'(bcd);
                  else if (an == 4'b0111) seen[3] = int'(bcd);
                  else an_ok = 1'b0;
               end
               chk("an_onehot_low", int'(an_ok), 1);
               chk("digit0", seen[0], int'(cur.d0));
               chk("digit1", seen[1], int'(cur.d1));
               chk("digit2", seen[2], 15);
               chk("digit3", seen[3], int'(cur.d3));
               $display("txn: done@%0d digits %0h %0h %0h %0h", cur.done_cyc,
                        seen[3], seen[2], seen[1], seen[0]);
            end
         end
      end
   end

   task automatic run_op(input vec_t v);
      exp_t e;
      int   busy_n;
      @(negedge clk);
      A = v.a; B = v.b; Sel = v.s; start = 1'b1;
      @(posedge clk);
      #1;
      e.done_cyc = cyc + 2 + v.k;
      e.d0 = v.d0; e.d1 = v.d1; e.d3 = v.d3;
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk("alu_a", int'(alu_a), int'(v.a));
      chk("alu_b", int'(alu_b), int'(v.b));
      chk("alu_sel", int'(alu_sel), int'(v.s));
      busy_n = 0;
      while (busy === 1'b1 && busy_n < 20) begin
         busy_n++;
         @(negedge clk);
      end
      chk("busy_cycles", busy_n, 3 + v.k);
      $display("txn: A=%0d B=%0d Sel=%0d busy=%0d cycles", v.a, v.b, v.s, busy_n);
      repeat (24) @(negedge clk);
   endtask

   vec_t vecs [8];
   int   nd;
   exp_t e2;

   initial begin
      vecs[0] = '{4'd2,  4'd3,  1'b0, 4'd5, 4'hF, 4'hF, 0};  //  5
      vecs[1] = '{4'd2,  4'd3,  1'b1, 4'd1, 4'hF, 4'hA, 0};  // -1
      vecs[2] = '{4'd15, 4'd15, 1'b0, 4'd0, 4'd3, 4'hF, 3};  // 30
      vecs[3] = '{4'd0,  4'd15, 1'b1, 4'd5, 4'd1, 4'hA, 1};  // -15
      vecs[4] = '{4'd7,  4'd7,  1'b1, 4'd0, 4'hF, 4'hF, 0};  //  0
      vecs[5] = '{4'd9,  4'd4,  1'b1, 4'd5, 4'hF, 4'hF, 0};  //  5
      vecs[6] = '{4'd3,  4'd12, 1'b1, 4'd9, 4'hF, 4'hA, 0};  // -9
      vecs[7] = '{4'd8,  4'd5,  1'b0, 4'd3, 4'd1, 4'hF, 1};  // 13

      // Reset state
      A = 4'd9; B = 4'd6; Sel = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_an", int'(an), 14);
      chk("rst_bcd", int'(bcd), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_alu_a", int'(alu_a), 0);
      chk("rst_alu_b", int'(alu_b), 0);
      chk("rst_alu_sel", int'(alu_sel), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      foreach (vecs[i]) run_op(vecs[i]);

      // start held high: exactly one operation
      nd = n_done;
      @(negedge clk);
      A = 4'd4; B = 4'd1; Sel = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      e2.done_cyc = cyc + 2; e2.d0 = 4'd5; e2.d1 = 4'hF; e2.d3 = 4'hF;
      sb.push_back(e2);
      repeat (20) @(negedge clk);
      start = 1'b0;
      repeat (24) @(negedge clk);
      chk("hold_high_dones", n_done - nd, 1);
      $display("txn: start held high, dones=%0d", n_done - nd);

      // second edge while busy is ignored
      nd = n_done;
      @(negedge clk);
      A = 4'd15; B = 4'd15; Sel = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      e2.done_cyc = cyc + 5; e2.d0 = 4'd0; e2.d1 = 4'd3; e2.d3 = 4'hF;
      sb.push_back(e2);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      A = 4'd1; B = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      chk("busy_edge_dones", n_done - nd, 1);
      chk("busy_edge_alu_a", int'(alu_a), 15);
      $display("txn: edge while busy, dones=%0d alu_a=%0d", n_done - nd, alu_a);

      // reset while in CONV aborts
      @(negedge clk);
      A = 4'd15; B = 4'd15; Sel = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      nd = n_done;
      @(posedge clk);
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_an", int'(an), 14);
      chk("abort_bcd", int'(bcd), 0);
      chk("abort_done", int'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_dones", n_done - nd, 0);
      $display("txn: reset in CONV, busy=%0d dones=%0d", busy, n_done - nd);

      // scan sequence from reset: each pattern lasts DIV cycles
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 32; j++) begin
         chk("scan_an", int'(an), int'(~(4'b0001 << ((j / DIV) % 4)) & 4'hF));
         @(negedge clk);
      end
      $display("txn: scan check 32 cycles done");

      chk("queue_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
